// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: reads vectors A and B from two 1-cycle-latency RAMs and accumulates a*b.
// Optional macro DOTP_SIGNED_EN selects two's complement operands with a sign-extended product.
module dot_product_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  a_read_en,
  output logic [ADDR_WIDTH-1:0] a_read_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  b_read_en,
  output logic [ADDR_WIDTH-1:0] b_read_address,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [1:0]            dbg_state
);

  // Handshake: result transfers on a cycle where result_valid & result_ready are both high;
  // result_valid stays high and result stays stable until that cycle.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH:0]     r_len;
  logic [ADDR_WIDTH:0]     r_idx;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_rd_en;
  logic                    r_dv;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [ACC_WIDTH-1:0]    r_result;
  logic                    r_result_valid;
  logic                    r_busy;
  logic [ACC_WIDTH-1:0]    w_prod_ext;

`ifdef DOTP_SIGNED_EN
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  assign w_prod     = $signed(a_data) * $signed(b_data);
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
`else
  logic [2*DATA_WIDTH-1:0] w_prod;
  assign w_prod     = a_data * b_data;
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, w_prod};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_idx          <= '0;
      r_addr         <= '0;
      r_rd_en        <= 1'b0;
      r_dv           <= 1'b0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // Read data arrives one cycle after the enable, so the valid flag trails it.
      r_dv <= r_rd_en;
      if (r_dv) r_acc <= r_acc + w_prod_ext;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len  <= len;
            r_idx  <= '0;
            r_acc  <= '0;
            r_busy <= 1'b1;
            if (len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= base_addr;
              r_rd_en <= 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_idx == r_len - (ADDR_WIDTH+1)'(1)) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_idx  <= r_idx + (ADDR_WIDTH+1)'(1);
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle captures the settled accumulator; later cycles wait for ready.
          if (!r_result_valid) begin
            r_result       <= r_acc;
            r_result_valid <= 1'b1;
          end else if (result_ready) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign a_read_en      = r_rd_en;
  assign b_read_en      = r_rd_en;
  assign a_read_address = r_addr;
  assign b_read_address = r_addr;
  assign result         = r_result;
  assign result_valid   = r_result_valid;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: RAM models, a reference sum/address model and
// one negedge compare process, plus literal expectations for the directed vectors.
module tb_dot_product_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int ACC = 2*DW+AW;
  localparam int DEPTH = 1 << AW;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [AW:0]    len;
  logic           busy;
  logic           a_read_en;
  logic [AW-1:0]  a_read_address;
  logic [DW-1:0]  a_data;
  logic           b_read_en;
  logic [AW-1:0]  b_read_address;
  logic [DW-1:0]  b_data;
  logic [ACC-1:0] result;
  logic           result_valid;
  logic           result_ready;
  logic [1:0]     dbg_state;

  logic [DW-1:0]  mem_a [DEPTH];
  logic [DW-1:0]  mem_b [DEPTH];

  logic [AW-1:0]  exp_q[$];
  logic [ACC-1:0] exp_res;
  int             checks;
  int             errors;

  dot_product_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .a_read_en(a_read_en), .a_read_address(a_read_address), .a_data(a_data),
    .b_read_en(b_read_en), .b_read_address(b_read_address), .b_data(b_data),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models
  always @(posedge clk) begin
    if (a_read_en) a_data <= mem_a[a_read_address];
    if (b_read_en) b_data <= mem_b[b_read_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ACC-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef DOTP_SIGNED_EN
    return ACC'($signed(a) * $signed(b));
`else
    return ACC'(a) * ACC'(b);
`endif
  endfunction

  // Compare process: every read must match the next expected address, result must match model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_read_en || b_read_en) begin
        chk("rd_en_pair", {63'd0, a_read_en}, {63'd0, b_read_en});
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 64'd1, 64'd0);
        end else begin
          chk("a_addr", 64'(a_read_address), 64'(exp_q[0]));
          chk("b_addr", 64'(b_read_address), 64'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (result_valid) chk("result", 64'(result), 64'(exp_res));
    end
  end

  // Driver: one run with optional backpressure window and optional literal expectation.
  task automatic run(input int base, input int ln, input int hold,
                     input bit use_lit, input logic [ACC-1:0] lit);
    int             lat;
    int             exp_lat;
    logic [AW-1:0]  addr;
    logic [ACC-1:0] sum;
    logic [ACC-1:0] held;
    exp_q.delete();
    sum = '0;
    for (int i = 0; i < ln; i++) begin
      addr = AW'((base + i) % DEPTH);
      exp_q.push_back(addr);
      sum = sum + prod(mem_a[addr], mem_b[addr]);
    end
    exp_res = sum;
    exp_lat = (ln == 0) ? 1 : ln + 2;
    base_addr    = AW'(base);
    len          = (AW+1)'(ln);
    result_ready = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("reads_issued", 64'(exp_q.size()), 64'd0);
    if (use_lit) chk("result_literal", 64'(result), 64'(lit));
    held = result;
    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      @(negedge clk);
      chk("hold_valid", {63'd0, result_valid}, 64'd1);
      chk("hold_result", 64'(result), 64'(held));
    end
    start        = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("valid_after_hs", {63'd0, result_valid}, 64'd0);
    chk("busy_after_hs", {63'd0, busy}, 64'd0);
    chk("result_kept", 64'(result), 64'(held));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    result_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rd_en", {62'd0, a_read_en, b_read_en}, 64'd0);
    chk("rst_valid", {63'd0, result_valid}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_addr", {56'd0, a_read_address, b_read_address}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: basic, full length, wrap, zero length
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 5);
    end
    run(0, 4, 0, 1'b1, ACC'(70));
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'hFF;
    end
`ifndef DOTP_SIGNED_EN
    run(0, 16, 0, 1'b1, ACC'('hFE010));
`else
    run(0, 16, 0, 1'b1, ACC'(16));
`endif
    for (int i = 0; i < 4; i++) begin
      mem_a[(14 + i) % DEPTH] = DW'(i + 1);
      mem_b[(14 + i) % DEPTH] = DW'(i + 1);
    end
    run(14, 4, 0, 1'b1, ACC'(30));
    run(3, 0, 0, 1'b1, ACC'(0));

    // Backpressure with an ignored start pulse in DONE
    run(0, 4, 5, 1'b0, '0);

    // Signed/unsigned operand interpretation
    mem_a[0] = 8'hFF;
    mem_b[0] = 8'h02;
`ifdef DOTP_SIGNED_EN
    run(0, 1, 0, 1'b1, ACC'('hFFFFE));
`else
    run(0, 1, 0, 1'b1, ACC'('h001FE));
`endif

    // Abort mid-READ, then a fresh run
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'($urandom_range(0, 255));
      mem_b[i] = DW'($urandom_range(0, 255));
    end
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(AW'((2 + i) % DEPTH));
    base_addr = AW'(2);
    len = (AW+1)'(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_rd_en", {62'd0, a_read_en, b_read_en}, 64'd0);
    chk("abort_valid", {63'd0, result_valid}, 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_addr", {56'd0, a_read_address, b_read_address}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(2, 10, 0, 1'b0, '0);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] = DW'($urandom_range(0, 255));
        mem_b[i] = DW'($urandom_range(0, 255));
      end
      run($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH), $urandom_range(0, 3), 1'b0, '0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
